// File: rtl/ram_dumper.sv
// Streams a range of 32-bit RAM words out of a UART TX line, LSB byte first.
// Words are fetched one at a time from a wide, 1-cycle-latency read port.
module ram_dumper #(
    parameter int unsigned CLK_FREQ         = 50_000_000,
    parameter int unsigned BAUD_RATE        = 115200,
    parameter int unsigned RAM_DEPTH        = 32768,
    parameter int unsigned CACHE_LINE_WIDTH = 128
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [$clog2(RAM_DEPTH)-1:0] base_addr_i,
    input  logic [15:0]                  word_count_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [$clog2(RAM_DEPTH)-1:0] mem_addr_o,
    output logic                         mem_rd_en_o,
    input  logic [CACHE_LINE_WIDTH-1:0]  mem_rdata_i,
    output logic                         uart_tx_o
);
    localparam int unsigned WORD_WIDTH   = 32;
    localparam int unsigned AW           = $clog2(RAM_DEPTH);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned OFF_W        = $clog2(CACHE_LINE_WIDTH);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] CAP  = 3'd2;
    localparam logic [2:0] TX   = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [15:0]           remaining_q, remaining_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      baud_q, baud_d;
    logic [3:0]            bit_q, bit_d;
    logic [1:0]            byte_q, byte_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  rd_en_q, rd_en_d;
    logic [AW-1:0]         mem_addr_q, mem_addr_d;
    logic [OFF_W-1:0]      lane_off;

    // Bit offset of the addressed 32-bit lane within the fetched line
    assign lane_off = OFF_W'({addr_q[1:0], 5'b00000});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            shift_q     <= '0;
            baud_q      <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            shift_q     <= shift_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        shift_d     = shift_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        tx_d        = tx_q;
        mem_addr_d  = mem_addr_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (word_count_i != 16'd0) begin
                        addr_d      = base_addr_i;
                        remaining_d = word_count_i;
                        state_d     = RD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RD: state_d = CAP;
            CAP: begin
                shift_d = mem_rdata_i[lane_off +: WORD_WIDTH];
                baud_d  = '0;
                bit_d   = 4'd0;
                byte_d  = 2'd0;
                tx_d    = 1'b0;
                state_d = TX;
            end
            TX: begin
                if (baud_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    baud_d = '0;
                    if (bit_q == 4'd9) begin
                        bit_d = 4'd0;
                        if (byte_q == 2'd3) begin
                            byte_d      = 2'd0;
                            tx_d        = 1'b1;
                            remaining_d = remaining_q - 16'd1;
                            addr_d      = (addr_q == AW'(RAM_DEPTH - 1)) ? '0 : addr_q + AW'(1);
                            state_d     = (remaining_d != 16'd0) ? RD : DONE;
                        end else begin
                            byte_d = byte_q + 2'd1;
                            tx_d   = 1'b0;
                        end
                    end else begin
                        // Data bits consume the shift register LSB-first; slot 0 is the start bit
                        if (bit_q != 4'd0) begin
                            shift_d = shift_q >> 1;
                        end
                        bit_d = bit_q + 4'd1;
                        tx_d  = (bit_q == 4'd8) ? 1'b1 : shift_d[0];
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d == RD) || (state_d == CAP) || (state_d == TX);
        done_d  = (state_d == DONE);
        rd_en_d = (state_d == RD);
        if (state_d == RD) begin
            mem_addr_d = addr_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign mem_rd_en_o = rd_en_q;
    assign mem_addr_o  = mem_addr_q;
    assign uart_tx_o   = tx_q;

endmodule

// File: tb/tb_ram_dumper.sv
// Scoreboard bench for ram_dumper: a line-wide RAM model, a UART decoder and
// read/done monitors feed observation queues that each scenario task compares.
module tb_ram_dumper;
    localparam int unsigned CPB   = 10;
    localparam int unsigned DEPTH = 256;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         start_i = 1'b0;
    logic [7:0]   base_addr_i = '0;
    logic [15:0]  word_count_i = '0;
    logic         busy_o, done_o, mem_rd_en_o, uart_tx_o;
    logic [7:0]   mem_addr_o;
    logic [127:0] mem_rdata_i = '0;

    logic [31:0]  mem [DEPTH];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ib = 0;
    int ia = 0;
    int id = 0;

    logic [7:0] ob_byte[$];
    bit         ob_ok[$];
    int         ob_start[$];
    logic [7:0] ob_addr[$];
    int         done_cyc[$];

    logic [7:0] exp_byte[$];
    logic [7:0] exp_addr[$];

    ram_dumper #(
        .CLK_FREQ(1_000_000),
        .BAUD_RATE(100_000),
        .RAM_DEPTH(DEPTH),
        .CACHE_LINE_WIDTH(128)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .start_i(start_i),
        .base_addr_i(base_addr_i),
        .word_count_i(word_count_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .mem_addr_o(mem_addr_o),
        .mem_rd_en_o(mem_rd_en_o),
        .mem_rdata_i(mem_rdata_i),
        .uart_tx_o(uart_tx_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // RAM model: registered 4-word line, one cycle after the read enable
    always @(posedge clk_i) begin
        if (mem_rd_en_o === 1'b1) begin
            mem_rdata_i <= {mem[{mem_addr_o[7:2], 2'd3}], mem[{mem_addr_o[7:2], 2'd2}],
                            mem[{mem_addr_o[7:2], 2'd1}], mem[{mem_addr_o[7:2], 2'd0}]};
        end
    end

    always @(negedge clk_i) begin
        if (mem_rd_en_o === 1'b1) ob_addr.push_back(mem_addr_o);
        if (done_o === 1'b1) done_cyc.push_back(cyc);
    end

    // UART decoder sampling mid-bit
    initial begin : uart_mon
        logic [7:0] b;
        bit         ok;
        int         st;
        forever begin
            @(negedge clk_i);
            if (uart_tx_o === 1'b0) begin
                st = cyc;
                ok = 1'b1;
                repeat (CPB / 2) @(negedge clk_i);
                if (uart_tx_o !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk_i);
                    b[i] = uart_tx_o;
                end
                repeat (CPB) @(negedge clk_i);
                if (uart_tx_o !== 1'b1) ok = 1'b0;
                ob_byte.push_back(b);
                ob_ok.push_back(ok);
                ob_start.push_back(st);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    function automatic logic [31:0] pat(input int i);
        return {8'(i * 7 + 1), 8'(i ^ 8'hA5), 8'(i + 8'h30), 8'(~i)};
    endfunction

    task automatic push_word(input int a);
        logic [31:0] w;
        w = mem[a];
        for (int k = 0; k < 4; k++) exp_byte.push_back(w[k*8 +: 8]);
        exp_addr.push_back(8'(a));
    endtask

    task automatic pulse_start(input logic [7:0] base, input logic [15:0] cnt);
        @(posedge clk_i); #1;
        start_i = 1'b1;
        base_addr_i = base;
        word_count_i = cnt;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        base_addr_i = '0;
        word_count_i = '0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk_i);
            if (done_cyc.size() > id) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_i); #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done_o); end
        total++; if (mem_rd_en_o !== 1'b0) begin bad++; $display("FAIL reset rd_en: got %b want 0", mem_rd_en_o); end
        total++; if (mem_addr_o !== 8'd0) begin bad++; $display("FAIL reset addr: got %0h want 0", mem_addr_o); end
        total++; if (uart_tx_o !== 1'b1) begin bad++; $display("FAIL reset tx: got %b want 1", uart_tx_o); end
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
    endtask

    task automatic test_single(input string name, input logic [7:0] base, input logic [31:0] value);
        bit ok;
        int bs;
        logic [7:0] e;
        mem[base] = value;
        push_word(base);
        bs = ib;
        pulse_start(base, 16'd1);
        wait_done(1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL %s done: got timeout want pulse", name); end
        while (exp_addr.size() > 0) begin
            e = exp_addr.pop_front();
            total++;
            if (ia >= ob_addr.size()) begin bad++; $display("FAIL %s read: got none want %0h", name, e); end
            else begin
                if (ob_addr[ia] !== e) begin bad++; $display("FAIL %s read: got %0h want %0h", name, ob_addr[ia], e); end
                ia++;
            end
        end
        total++; if (ob_addr.size() != ia) begin bad++; $display("FAIL %s reads: got %0d want %0d", name, ob_addr.size(), ia); ia = ob_addr.size(); end
        while (exp_byte.size() > 0) begin
            e = exp_byte.pop_front();
            total++;
            if (ib >= ob_byte.size()) begin bad++; $display("FAIL %s byte: got none want %02h", name, e); end
            else begin
                if (ob_byte[ib] !== e || !ob_ok[ib]) begin
                    bad++; $display("FAIL %s byte%0d: got %02h frame %0b want %02h frame 1", name, ib - bs, ob_byte[ib], ob_ok[ib], e);
                end
                ib++;
            end
        end
        total++; if (ob_byte.size() != ib) begin bad++; $display("FAIL %s bytes: got %0d want %0d", name, ob_byte.size(), ib); ib = ob_byte.size(); end
        if (ok && bs < ob_start.size()) begin
            total++;
            if (done_cyc[id] - ob_start[bs] != 400) begin
                bad++; $display("FAIL %s latency: got %0d want 400", name, done_cyc[id] - ob_start[bs]);
            end
            id++;
        end
        @(negedge clk_i);
        total++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL %s post: got done=%b busy=%b want 0 0", name, done_o, busy_o); end
    endtask

    task automatic test_multiword(input string name, input int base, input int cnt);
        bit ok;
        int bs, gap, lim;
        logic [7:0] e;
        for (int a = 0; a < cnt; a++) push_word((base + a) % DEPTH);
        bs = ib;
        pulse_start(8'(base), 16'(cnt));
        wait_done(cnt * 500 + 100, ok);
        total++; if (!ok) begin bad++; $display("FAIL %s done: got timeout want pulse", name); end
        if (ok) id++;
        while (exp_addr.size() > 0) begin
            e = exp_addr.pop_front();
            total++;
            if (ia >= ob_addr.size()) begin bad++; $display("FAIL %s read: got none want %0h", name, e); end
            else begin
                if (ob_addr[ia] !== e) begin bad++; $display("FAIL %s read: got %0h want %0h", name, ob_addr[ia], e); end
                ia++;
            end
        end
        total++; if (ob_addr.size() != ia) begin bad++; $display("FAIL %s reads: got %0d want %0d", name, ob_addr.size(), ia); ia = ob_addr.size(); end
        while (exp_byte.size() > 0) begin
            e = exp_byte.pop_front();
            total++;
            if (ib >= ob_byte.size()) begin bad++; $display("FAIL %s byte: got none want %02h", name, e); end
            else begin
                if (ob_byte[ib] !== e || !ob_ok[ib]) begin
                    bad++; $display("FAIL %s byte%0d: got %02h frame %0b want %02h frame 1", name, ib - bs, ob_byte[ib], ob_ok[ib], e);
                end
                ib++;
            end
        end
        total++; if (ob_byte.size() != ib) begin bad++; $display("FAIL %s bytes: got %0d want %0d", name, ob_byte.size(), ib); ib = ob_byte.size(); end
        // Within a word bytes abut exactly; between words the gap stays below one bit time
        for (int k = bs + 1; k < ib && k < ob_start.size(); k++) begin
            gap = ob_start[k] - ob_start[k-1];
            lim = ((k - bs) % 4 == 0) ? 10 * CPB + CPB - 1 : 10 * CPB;
            total++;
            if (gap < 10 * CPB || gap > lim) begin
                bad++; $display("FAIL %s spacing%0d: got %0d want %0d..%0d", name, k - bs, gap, 10 * CPB, lim);
            end
        end
    endtask

    task automatic test_zero_count();
        int a0, d0;
        bit saw_busy, saw_tx0;
        a0 = ob_addr.size();
        d0 = done_cyc.size();
        saw_busy = 1'b0;
        saw_tx0 = 1'b0;
        @(posedge clk_i); #1;
        start_i = 1'b1;
        word_count_i = 16'd0;
        base_addr_i = 8'd9;
        @(negedge clk_i);
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL zero early: got done=%b want 0", done_o); end
        @(posedge clk_i); #1;
        start_i = 1'b0;
        base_addr_i = '0;
        total++; if (done_o !== 1'b1) begin bad++; $display("FAIL zero done: got %b want 1", done_o); end
        @(posedge clk_i); #1;
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL zero pulse: got %b want 0", done_o); end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (busy_o !== 1'b0) saw_busy = 1'b1;
            if (uart_tx_o !== 1'b1) saw_tx0 = 1'b1;
        end
        total++; if (saw_busy) begin bad++; $display("FAIL zero busy: got 1 want 0"); end
        total++; if (saw_tx0) begin bad++; $display("FAIL zero tx: got 0 want 1"); end
        total++; if (ob_addr.size() != a0) begin bad++; $display("FAIL zero reads: got %0d want %0d", ob_addr.size() - a0, 0); end
        total++; if (done_cyc.size() != d0 + 1) begin bad++; $display("FAIL zero dones: got %0d want 1", done_cyc.size() - d0); end
        ia = ob_addr.size();
        id = done_cyc.size();
    endtask

    task automatic test_ignored_start();
        bit ok;
        int bs;
        logic [7:0] e;
        push_word(10);
        push_word(11);
        bs = ib;
        pulse_start(8'd10, 16'd2);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk_i);
            if (ob_byte.size() > bs) ok = 1'b1;
        end
        total++; if (!ok) begin bad++; $display("FAIL ignored first_byte: got timeout want byte"); end
        pulse_start(8'd40, 16'd7);
        wait_done(1500, ok);
        total++; if (!ok) begin bad++; $display("FAIL ignored done: got timeout want pulse"); end
        repeat (30) @(negedge clk_i);
        total++; if (done_cyc.size() != id + 1) begin bad++; $display("FAIL ignored dones: got %0d want 1", done_cyc.size() - id); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL ignored busy: got %b want 0", busy_o); end
        id = done_cyc.size();
        while (exp_addr.size() > 0) begin
            e = exp_addr.pop_front();
            total++;
            if (ia >= ob_addr.size()) begin bad++; $display("FAIL ignored read: got none want %0h", e); end
            else begin
                if (ob_addr[ia] !== e) begin bad++; $display("FAIL ignored read: got %0h want %0h", ob_addr[ia], e); end
                ia++;
            end
        end
        total++; if (ob_addr.size() != ia) begin bad++; $display("FAIL ignored reads: got %0d want %0d", ob_addr.size(), ia); ia = ob_addr.size(); end
        while (exp_byte.size() > 0) begin
            e = exp_byte.pop_front();
            total++;
            if (ib >= ob_byte.size()) begin bad++; $display("FAIL ignored byte: got none want %02h", e); end
            else begin
                if (ob_byte[ib] !== e || !ob_ok[ib]) begin
                    bad++; $display("FAIL ignored byte%0d: got %02h frame %0b want %02h frame 1", ib - bs, ob_byte[ib], ob_ok[ib], e);
                end
                ib++;
            end
        end
        total++; if (ob_byte.size() != ib) begin bad++; $display("FAIL ignored bytes: got %0d want %0d", ob_byte.size(), ib); ib = ob_byte.size(); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok, saw_busy;
        int d0;
        mem[20] = 32'h1234_00FF;
        d0 = done_cyc.size();
        pulse_start(8'd20, 16'd3);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk_i);
            if (uart_tx_o === 1'b0) ok = 1'b1;
        end
        total++; if (!ok) begin bad++; $display("FAIL rstmid start: got timeout want start bit"); end
        // 144 cycles past the first start bit lands inside data bit 3 of byte 1
        repeat (144) @(posedge clk_i);
        #2;
        total++; if (uart_tx_o !== 1'b0) begin bad++; $display("FAIL rstmid pre_tx: got %b want 0", uart_tx_o); end
        rst_i = 1'b1;
        #1;
        total++; if (uart_tx_o !== 1'b1) begin bad++; $display("FAIL rstmid tx: got %b want 1", uart_tx_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rstmid busy: got %b want 0", busy_o); end
        repeat (3) @(posedge clk_i); #1;
        rst_i = 1'b0;
        saw_busy = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_i);
            if (busy_o !== 1'b0) saw_busy = 1'b1;
        end
        total++; if (saw_busy) begin bad++; $display("FAIL rstmid resume: got busy want idle"); end
        total++; if (done_cyc.size() != d0) begin bad++; $display("FAIL rstmid done: got %0d pulses want 0", done_cyc.size() - d0); end
        total++;
        if (ib >= ob_byte.size()) begin bad++; $display("FAIL rstmid byte0: got none want ff"); end
        else if (ob_byte[ib] !== 8'hFF || !ob_ok[ib]) begin bad++; $display("FAIL rstmid byte0: got %02h want ff", ob_byte[ib]); end
        ib = ob_byte.size();
        ia = ob_addr.size();
        id = done_cyc.size();
    endtask

    initial begin : main
        for (int i = 0; i < DEPTH; i++) mem[i] = pat(i);
        test_reset();
        test_single("single", 8'd5, 32'hA55A_1234);
        test_multiword("multi", 2, 4);
        test_multiword("wrap", DEPTH - 1, 2);
        test_zero_count();
        test_ignored_start();
        test_reset_mid_frame();
        test_single("after_reset", 8'd7, 32'h0F1E_2D3C);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
